// File: rtl/bisls_tx_pkg.sv
// Shared definitions for the BISLS result transmitter: framing constants,
// status-byte layout and the frame sequencer state.
package bisls_tx_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 15;

  // Status byte layout; bits 3:2 are always zero.
  localparam int ST_ERR  = 7;
  localparam int ST_CNT  = 6;
  localparam int ST_DIAG = 5;
  localparam int ST_MED  = 4;
  localparam int ST_QUAD = 0;

  typedef enum logic {IDLE, SEND} tx_state_e;

  typedef struct packed {
    logic [7:0]  status;
    logic [31:0] p;
    logic [31:0] q;
    logic [31:0] r;
  } result_t;

  function automatic logic [7:0] status_byte(input logic err, input logic cnt,
                                             input logic diag, input logic med,
                                             input logic [1:0] quad);
    logic [7:0] s;
    s               = 8'h00;
    s[ST_ERR]       = err;
    s[ST_CNT]       = cnt;
    s[ST_DIAG]      = diag;
    s[ST_MED]       = med;
    s[ST_QUAD+:2]   = quad;
    return s;
  endfunction

endpackage

// File: rtl/bisls_result_tx_if.sv
// Result handoff from the value assigner and the UART/status side of the transmitter.
interface bisls_result_tx_if;
  logic        Result_Ready;
  logic [31:0] P;
  logic [31:0] Q;
  logic [31:0] R;
  logic [1:0]  Quadrent;
  logic        Flag_ERR;
  logic        Flag_CNT;
  logic        Flag_DIAG;
  logic        Flag_MED;
  logic        TXD;
  logic        TX_Busy;
  logic        Frame_Done;
  logic        Overrun;

  modport master (output Result_Ready, P, Q, R, Quadrent, Flag_ERR, Flag_CNT, Flag_DIAG, Flag_MED,
                  input  TXD, TX_Busy, Frame_Done, Overrun);
  modport slave  (input  Result_Ready, P, Q, R, Quadrent, Flag_ERR, Flag_CNT, Flag_DIAG, Flag_MED,
                  output TXD, TX_Busy, Frame_Done, Overrun);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start accepted in the last stop-bit cycle (done) chains
// the next byte with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       txd
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;   // 0 start, 1..8 data, 9 stop
  logic [8:0]    shreg;     // remaining data bits with the stop bit behind them
  logic          bit_end;

  assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign done    = busy & bit_end & (bit_idx == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      shreg    <= '1;
    end else if (start && (!busy || done)) begin
      busy     <= 1'b1;
      txd      <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      shreg    <= {1'b1, data};
    end else if (busy) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          busy <= 1'b0;
          txd  <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          txd     <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bisls_result_tx.sv
// Captures one BISLS result on the rising edge of Result_Ready and sends it
// as a 15-byte SYNC/status/P/Q/R/checksum packet over 8N1 UART.
module bisls_result_tx
  import bisls_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic             Gbl_CLK,
  input  logic             RST_EX_N,
  bisls_result_tx_if.slave bus
);

  tx_state_e    state;
  result_t      cap;
  logic [3:0]   byte_idx;
  logic [7:0]   csum;
  logic         rr_prev;
  logic         frame_done_q;
  logic         overrun_q;

  logic         rr_edge, last_done, accept, advance;
  logic [3:0]   next_idx, rev;
  logic [127:0] pqr;
  logic [7:0]   mux_byte;
  logic         ser_start, ser_busy, ser_done, ser_txd;
  logic [7:0]   ser_data;

  assign rr_edge   = bus.Result_Ready & ~rr_prev;
  assign last_done = (state == SEND) & ser_done & (byte_idx == 4'(FRAME_BYTES - 1));
  // A new edge landing on the final stop-bit cycle chains straight into the next frame.
  assign accept    = rr_edge & ((state == IDLE) | last_done);
  assign advance   = (state == SEND) & ser_done & ~last_done;
  assign next_idx  = byte_idx + 4'd1;
  assign ser_start = accept | advance;
  assign ser_data  = accept ? SYNC_BYTE : mux_byte;

  // Bytes 2..13 are P,Q,R MSB first; zero pad keeps every slice index in range.
  always_comb begin
    pqr      = {32'd0, cap.p, cap.q, cap.r};
    rev      = 4'd13 - next_idx;
    mux_byte = pqr[{rev, 3'b000} +: 8];
    if (next_idx == 4'd1)                        mux_byte = cap.status;
    else if (next_idx == 4'(FRAME_BYTES - 1))    mux_byte = csum;
  end

  always_ff @(posedge Gbl_CLK or negedge RST_EX_N) begin
    if (!RST_EX_N) begin
      state        <= IDLE;
      cap          <= '0;
      byte_idx     <= 4'd0;
      csum         <= 8'h00;
      rr_prev      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rr_prev      <= bus.Result_Ready;
      frame_done_q <= last_done;
      if (rr_edge && !accept) overrun_q <= 1'b1;
      if (accept) begin
        cap      <= '{status: status_byte(bus.Flag_ERR, bus.Flag_CNT, bus.Flag_DIAG,
                                          bus.Flag_MED, bus.Quadrent),
                      p: bus.P, q: bus.Q, r: bus.R};
        byte_idx <= 4'd0;
        csum     <= 8'h00;
        state    <= SEND;
      end else if (last_done) begin
        byte_idx <= 4'd0;
        state    <= IDLE;
      end else if (advance) begin
        byte_idx <= next_idx;
        // Sum bytes 1..13 as they are handed off; the checksum byte itself is not added.
        if (next_idx != 4'(FRAME_BYTES - 1)) csum <= csum + ser_data;
      end
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk   (Gbl_CLK),
    .rst_n (RST_EX_N),
    .start (ser_start),
    .data  (ser_data),
    .busy  (ser_busy),
    .done  (ser_done),
    .txd   (ser_txd)
  );

  assign bus.TXD        = ser_txd;
  assign bus.TX_Busy    = ser_busy;
  assign bus.Frame_Done = frame_done_q;
  assign bus.Overrun    = overrun_q;

endmodule

// File: tb/tb_bisls_result_tx.sv
// Directed bench for bisls_result_tx: decodes the UART line and compares
// each frame against hand-computed bytes.
module tb_bisls_result_tx;

  localparam int CPB = 4;

  logic Gbl_CLK  = 1'b0;
  logic RST_EX_N = 1'b0;
  int   cyc      = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   rx_c0    = 0;
  int   t_rr     = 0;
  int   frm_err  = 0;
  logic [7:0] rx_buf  [15];
  logic [7:0] exp_buf [15];

  bisls_result_tx_if bus ();

  bisls_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .Gbl_CLK  (Gbl_CLK),
    .RST_EX_N (RST_EX_N),
    .bus      (bus)
  );

  always #5 Gbl_CLK = ~Gbl_CLK;
  always @(posedge Gbl_CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic err, input logic cnt, input logic diag, input logic med,
                       input logic [1:0] quad, input logic [31:0] p, input logic [31:0] q,
                       input logic [31:0] r);
    bus.Flag_ERR = err; bus.Flag_CNT = cnt; bus.Flag_DIAG = diag; bus.Flag_MED = med;
    bus.Quadrent = quad; bus.P = p; bus.Q = q; bus.R = r;
  endtask

  // Called at a negedge; returns at the negedge where the start bit is first visible.
  task automatic send_pulse();
    bus.Result_Ready = 1'b1;
    t_rr = cyc;
    @(negedge Gbl_CLK);
    bus.Result_Ready = 1'b0;
  endtask

  task automatic rx_frame();
    int w;
    frm_err = 0;
    for (int k = 0; k < 15; k++) rx_buf[k] = 8'h00;
    for (int k = 0; k < 15; k++) begin
      w = 0;
      while (bus.TXD !== 1'b0 && w < 3000) begin @(negedge Gbl_CLK); w++; end
      if (bus.TXD !== 1'b0) begin chk("rx_timeout", 32'd1, 32'd0); return; end
      if (k == 0) rx_c0 = cyc;
      repeat (2) @(negedge Gbl_CLK);
      if (bus.TXD !== 1'b0) frm_err++;
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) @(negedge Gbl_CLK);
        rx_buf[k][b] = bus.TXD;
      end
      repeat (CPB) @(negedge Gbl_CLK);
      if (bus.TXD !== 1'b1) frm_err++;
    end
    chk("rx_framing", 32'(frm_err), 32'd0);
  endtask

  task automatic cmp_frame(input string pfx);
    for (int i = 0; i < 15; i++)
      chk($sformatf("%s_byte%0d", pfx, i), {24'd0, rx_buf[i]}, {24'd0, exp_buf[i]});
  endtask

  task automatic wait_done(input string pfx);
    int w;
    w = 0;
    while (bus.Frame_Done !== 1'b1 && w < 100) begin @(negedge Gbl_CLK); w++; end
    chk({pfx, "_done_lat"}, 32'(cyc - rx_c0), 32'd600);
    chk({pfx, "_busy_at_done"}, {31'd0, bus.TX_Busy}, 32'd0);
    @(negedge Gbl_CLK);
    chk({pfx, "_done_pulse"}, {31'd0, bus.Frame_Done}, 32'd0);
  endtask

  initial begin
    int lows;
    bus.Result_Ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
    repeat (3) @(negedge Gbl_CLK);
    chk("rst_txd",     {31'd0, bus.TXD},        32'd1);
    chk("rst_busy",    {31'd0, bus.TX_Busy},    32'd0);
    chk("rst_done",    {31'd0, bus.Frame_Done}, 32'd0);
    chk("rst_overrun", {31'd0, bus.Overrun},    32'd0);
    RST_EX_N = 1'b1;
    repeat (3) @(negedge Gbl_CLK);

    // Basic frame
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h10, 32'h20, 32'h30);
    exp_buf = '{8'hA5, 8'h12, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
                8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h30, 8'h72};
    send_pulse();
    chk("basic_busy_start", {31'd0, bus.TX_Busy}, 32'd1);
    rx_frame();
    chk("basic_start_lat", 32'(rx_c0), 32'(t_rr + 1));
    cmp_frame("basic");
    wait_done("basic");
    repeat (5) @(negedge Gbl_CLK);

    // Checksum wrap: every input bit set; bits 3:2 of the status byte stay 0,
    // so status is F3 and the sum is F3 + 12*FF = 0xCE7 -> E7.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exp_buf = '{8'hA5, 8'hF3, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hE7};
    send_pulse();
    rx_frame();
    cmp_frame("wrap");
    wait_done("wrap");
    repeat (5) @(negedge Gbl_CLK);

    // Back-to-back: second edge lands in the cycle that raises Frame_Done
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h10, 32'h20, 32'h30);
    exp_buf = '{8'hA5, 8'h12, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
                8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h30, 8'h72};
    send_pulse();
    rx_frame();
    cmp_frame("b2b1");
    @(negedge Gbl_CLK);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C);
    bus.Result_Ready = 1'b1;
    @(negedge Gbl_CLK);
    bus.Result_Ready = 1'b0;
    chk("b2b_done",    {31'd0, bus.Frame_Done}, 32'd1);
    chk("b2b_lat",     32'(cyc - rx_c0),        32'd600);
    chk("b2b_nogap",   {31'd0, bus.TXD},        32'd0);
    chk("b2b_overrun", {31'd0, bus.Overrun},    32'd0);
    exp_buf = '{8'hA5, 8'hA1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'hEF};
    rx_frame();
    cmp_frame("b2b2");
    wait_done("b2b2");
    repeat (5) @(negedge Gbl_CLK);

    // Held level: one frame only over 2000 cycles
    drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF, 32'h0, 32'h80);
    exp_buf = '{8'hA5, 8'h40, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'hF8};
    bus.Result_Ready = 1'b1;
    t_rr = cyc;
    @(negedge Gbl_CLK);
    rx_frame();
    cmp_frame("held");
    wait_done("held");
    lows = 0;
    while (cyc - t_rr < 2000) begin
      @(negedge Gbl_CLK);
      if (bus.TXD === 1'b0) lows++;
    end
    chk("held_extra_frame", 32'(lows), 32'd0);
    chk("held_overrun", {31'd0, bus.Overrun}, 32'd0);
    bus.Result_Ready = 1'b0;
    repeat (5) @(negedge Gbl_CLK);

    // Overrun: second edge ~cycle 100 into the frame with P changed
    drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    exp_buf = '{8'hA5, 8'h23, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22,
                8'h22, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33, 8'hBB};
    send_pulse();
    fork
      rx_frame();
      begin
        repeat (99) @(negedge Gbl_CLK);
        bus.P = 32'h9999_9999;
        bus.Result_Ready = 1'b1;
        @(negedge Gbl_CLK);
        bus.Result_Ready = 1'b0;
      end
    join
    cmp_frame("ovr");
    wait_done("ovr");
    chk("ovr_set", {31'd0, bus.Overrun}, 32'd1);
    lows = 0;
    repeat (300) begin
      @(negedge Gbl_CLK);
      if (bus.TXD === 1'b0) lows++;
    end
    chk("ovr_no_second", 32'(lows), 32'd0);
    chk("ovr_sticky", {31'd0, bus.Overrun}, 32'd1);

    // Reset mid-frame at byte 5
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h10, 32'h20, 32'h30);
    send_pulse();
    repeat (5 * 10 * CPB + 6) @(negedge Gbl_CLK);
    chk("pre_rst_busy", {31'd0, bus.TX_Busy}, 32'd1);
    #2 RST_EX_N = 1'b0;
    #1;
    chk("mid_rst_txd",     {31'd0, bus.TXD},     32'd1);
    chk("mid_rst_busy",    {31'd0, bus.TX_Busy}, 32'd0);
    chk("mid_rst_overrun", {31'd0, bus.Overrun}, 32'd0);
    @(negedge Gbl_CLK);
    RST_EX_N = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge Gbl_CLK);
      if (bus.TXD === 1'b0) lows++;
    end
    chk("post_rst_quiet", 32'(lows), 32'd0);
    exp_buf = '{8'hA5, 8'h12, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
                8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h30, 8'h72};
    send_pulse();
    rx_frame();
    cmp_frame("post_rst");
    wait_done("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
